// File: rtl/refclk_fwd_pkg.sv
// Shared types and constants for the forwarded reference clock generator.
package refclk_fwd_pkg;

    localparam int unsigned DIV_W_DEF = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StRun   = 2'd2
    } state_e;

    // DDR pad patterns: bit 0 drives the first half of the CLK period.
    localparam logic [1:0] PAT_LOW  = 2'b00;
    localparam logic [1:0] PAT_HIGH = 2'b11;
    localparam logic [1:0] PAT_FULL = 2'b01;

endpackage

// File: rtl/refclk_halfper_cnt.sv
// Half-period down-counter: reloads on zero and toggles the forwarded clock level.
module refclk_halfper_cnt #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [DIV_W-1:0] reload_i,
    output logic             zero_o,
    output logic             level_o,
    output logic             level_nxt_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (clr_i) begin
            cnt_d   = '0;
            level_d = 1'b0;
        end else if (load_i) begin
            // Entering the run: the first half is always high.
            cnt_d   = reload_i;
            level_d = 1'b1;
        end else if (step_i) begin
            if (cnt_q == '0) begin
                cnt_d   = reload_i;
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign zero_o      = (cnt_q == '0);
    assign level_o     = level_q;
    assign level_nxt_o = level_d;

endmodule

// File: rtl/refclk_fwd_gen.sv
// Forwarded reference clock generator: programmable-rate DDR clock pattern with
// config handshake and stop on full-period boundaries.
module refclk_fwd_gen
    import refclk_fwd_pkg::*;
#(
    parameter int unsigned DIV_W   = DIV_W_DEF,
    parameter int unsigned DIV_RST = 4,
    parameter int unsigned DIV_MAX = 200
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [DIV_W-1:0] CFG_DIV,
    input  logic             CFG_VALID,
    output logic             CFG_READY,
    output logic [1:0]       TX_DDR,
    output logic             TX_OE,
    output logic             ACTIVE,
    output logic             ERR_CFG
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             err_q, err_d;
    logic [1:0]       tx_ddr_q, tx_ddr_d;
    logic             tx_oe_q, tx_oe_d;
    logic             active_q, active_d;
    logic             ready_q, ready_d;

    logic             div_zero, cnt_zero, level, level_nxt;
    logic             period_end, cfg_fire, cfg_ok;
    logic [DIV_W-1:0] reload;

    assign div_zero = (div_q == '0);
    assign reload   = div_zero ? '0 : div_q - DIV_W'(1);
    // Last cycle of a low half; with N=0 every cycle is a full period.
    assign period_end = div_zero || (!level && cnt_zero);
    assign cfg_fire   = CFG_VALID && ready_q && (state_q == StIdle);
    assign cfg_ok     = 32'(CFG_DIV) <= DIV_MAX;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_fire) begin
                    if (cfg_ok) begin
                        div_d = CFG_DIV;
                        err_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (EN) begin
                    state_d = StStart;
                end
            end
            StStart: state_d = StRun;
            StRun: begin
                if (!EN && period_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    refclk_halfper_cnt #(
        .DIV_W (DIV_W)
    ) u_halfper_cnt (
        .CLK         (CLK),
        .RESET       (RESET),
        .clr_i       (state_d == StIdle),
        .load_i      (state_q == StStart),
        .step_i      (state_q == StRun),
        .reload_i    (reload),
        .zero_o      (cnt_zero),
        .level_o     (level),
        .level_nxt_o (level_nxt)
    );

    // Outputs are registered from next-state so they line up with the state they describe.
    always_comb begin
        ready_d  = (state_d == StIdle);
        tx_oe_d  = (state_d != StIdle);
        active_d = (state_d == StRun);
        tx_ddr_d = PAT_LOW;
        if (state_d == StRun) begin
            if (div_zero) begin
                tx_ddr_d = PAT_FULL;
            end else begin
                tx_ddr_d = level_nxt ? PAT_HIGH : PAT_LOW;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= StIdle;
            div_q    <= DIV_W'(DIV_RST);
            err_q    <= 1'b0;
            tx_ddr_q <= PAT_LOW;
            tx_oe_q  <= 1'b0;
            active_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            err_q    <= err_d;
            tx_ddr_q <= tx_ddr_d;
            tx_oe_q  <= tx_oe_d;
            active_q <= active_d;
            ready_q  <= ready_d;
        end
    end

    assign CFG_READY = ready_q;
    assign TX_DDR    = tx_ddr_q;
    assign TX_OE     = tx_oe_q;
    assign ACTIVE    = active_q;
    assign ERR_CFG   = err_q;

endmodule

// File: tb/tb_refclk_fwd_gen.sv
// Self-checking bench for refclk_fwd_gen: directed table, corner sequences, random vs model.
module tb_refclk_fwd_gen;

    logic       CLK = 1'b0;
    logic       RESET, EN, CFG_VALID;
    logic [7:0] CFG_DIV;
    logic       CFG_READY, TX_OE, ACTIVE, ERR_CFG;
    logic [1:0] TX_DDR;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: run phase counted in cycles, pattern derived arithmetically.
    int m_st, m_div, m_p;
    bit m_err;

    typedef struct {
        bit         rst;
        bit         en;
        bit         valid;
        int         div;
        logic [1:0] ddr;
        bit         oe;
        bit         act;
        bit         rdy;
        bit         err;
    } vec_t;

    vec_t tbl [17];

    refclk_fwd_gen #(
        .DIV_W   (8),
        .DIV_RST (4),
        .DIV_MAX (200)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .EN        (EN),
        .CFG_DIV   (CFG_DIV),
        .CFG_VALID (CFG_VALID),
        .CFG_READY (CFG_READY),
        .TX_DDR    (TX_DDR),
        .TX_OE     (TX_OE),
        .ACTIVE    (ACTIVE),
        .ERR_CFG   (ERR_CFG)
    );

    always #5 CLK = ~CLK;

    task automatic model_step(input bit rst, input bit en, input bit valid, input int div);
        int d;
        d = div & 255;
        if (rst) begin
            m_st = 0; m_div = 4; m_err = 0; m_p = 0;
        end else begin
            case (m_st)
                0: begin
                    if (valid) begin
                        if (d <= 200) begin
                            m_div = d; m_err = 0;
                        end else begin
                            m_err = 1;
                        end
                    end
                    if (en) m_st = 1;
                end
                1: begin
                    m_st = 2; m_p = 0;
                end
                default: begin
                    if (!en && (m_div == 0 || ((m_p + 1) % (2 * m_div)) == 0)) m_st = 0;
                    else m_p++;
                end
            endcase
        end
    endtask

    task automatic apply(input bit rst, input bit en, input bit valid, input int div);
        RESET = rst; EN = en; CFG_VALID = valid; CFG_DIV = 8'(div);
        @(posedge CLK);
        model_step(rst, en, valid, div);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] ddr, input bit oe, input bit act,
                         input bit rdy, input bit err);
        logic [5:0] got, exp;
        got = {TX_DDR, TX_OE, ACTIVE, CFG_READY, ERR_CFG};
        exp = {ddr, oe, act, rdy, err};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: ddr,oe,act,rdy,err got %b required %b", name, $time, got, exp);
        end
    endtask

    task automatic check_model(input string name);
        logic [1:0] ddr;
        ddr = 2'b00;
        if (m_st == 2) begin
            if (m_div == 0) ddr = 2'b01;
            else ddr = (((m_p / m_div) % 2) == 0) ? 2'b11 : 2'b00;
        end
        check(name, ddr, m_st != 0, m_st == 2, m_st == 0, m_err);
    endtask

    initial begin
        bit r_en, rst, valid;
        int div;
        RESET = 1'b1; EN = 1'b0; CFG_VALID = 1'b0; CFG_DIV = '0;

        //         rst en vld div  ddr    oe act rdy err
        tbl[0]  = '{1, 0, 0, 0,   2'b00, 0, 0, 1, 0};
        tbl[1]  = '{0, 1, 1, 1,   2'b00, 1, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0,   2'b11, 1, 1, 0, 0};
        tbl[3]  = '{0, 1, 0, 0,   2'b00, 1, 1, 0, 0};
        tbl[4]  = '{0, 1, 0, 0,   2'b11, 1, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 0,   2'b00, 1, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 0,   2'b00, 0, 0, 1, 0};
        tbl[7]  = '{0, 0, 1, 201, 2'b00, 0, 0, 1, 1};
        tbl[8]  = '{0, 1, 1, 0,   2'b00, 1, 0, 0, 0};
        tbl[9]  = '{0, 1, 1, 5,   2'b01, 1, 1, 0, 0};
        tbl[10] = '{0, 0, 0, 0,   2'b00, 0, 0, 1, 0};
        tbl[11] = '{0, 0, 1, 201, 2'b00, 0, 0, 1, 1};
        tbl[12] = '{0, 1, 0, 0,   2'b00, 1, 0, 0, 1};
        tbl[13] = '{0, 0, 0, 0,   2'b01, 1, 1, 0, 1};
        tbl[14] = '{0, 0, 0, 0,   2'b00, 0, 0, 1, 1};
        tbl[15] = '{0, 0, 1, 3,   2'b00, 0, 0, 1, 0};
        tbl[16] = '{1, 0, 0, 0,   2'b00, 0, 0, 1, 0};

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].valid, tbl[i].div);
            check($sformatf("table[%0d]", i), tbl[i].ddr, tbl[i].oe, tbl[i].act, tbl[i].rdy,
                  tbl[i].err);
        end

        // N=4, EN dropped on the second high cycle: two more highs, four lows, then idle.
        apply(0, 1, 0, 0); check("stop_start", 2'b00, 1, 0, 0, 0);
        apply(0, 1, 0, 0); check("stop_high1", 2'b11, 1, 1, 0, 0);
        apply(0, 1, 0, 0); check("stop_high2", 2'b11, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, 0, 0);
            check($sformatf("stop_tail[%0d]", i), (i < 2) ? 2'b11 : 2'b00, 1, 1, 0, 0);
        end
        apply(0, 0, 0, 0); check("stop_idle", 2'b00, 0, 0, 1, 0);

        // N=4, EN low for two low-half cycles and CFG_VALID held: pattern unbroken.
        apply(0, 1, 0, 0); check("glitch_start", 2'b00, 1, 0, 0, 0);
        for (int k = 0; k < 19; k++) begin
            apply(0, (k == 6 || k == 7) ? 1'b0 : 1'b1, 1, 1);
            check($sformatf("glitch[%0d]", k), (((k / 4) % 2) == 0) ? 2'b11 : 2'b00, 1, 1, 0, 0);
        end
        apply(1, 1, 0, 0); check("glitch_reset", 2'b00, 0, 0, 1, 0);

        // N=6 with a sticky error, reset on the third high cycle, then default N=4 restored.
        apply(0, 0, 1, 6);   check("rst_cfg6", 2'b00, 0, 0, 1, 0);
        apply(0, 0, 1, 250); check("rst_cfg250", 2'b00, 0, 0, 1, 1);
        apply(0, 1, 0, 0);   check("rst_start", 2'b00, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 0, 0); check($sformatf("rst_high[%0d]", i), 2'b11, 1, 1, 0, 1);
        end
        apply(1, 1, 0, 0); check("rst_mid_run", 2'b00, 0, 0, 1, 0);
        apply(0, 1, 0, 0); check("rst_restart", 2'b00, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 0, 0);
            check($sformatf("rst_div4[%0d]", i), (i < 4) ? 2'b11 : 2'b00, 1, 1, 0, 0);
        end

        // Random traffic against the reference model.
        r_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 11) == 0) r_en = !r_en;
            if ($urandom_range(0, 7) == 0) div = int'($urandom_range(0, 255));
            else div = int'($urandom_range(0, 5));
            apply(rst, r_en, valid, div);
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
